// File: rtl/frv_pipeline_source_pkg.sv
// Shared definitions for the pipeline source FIFO: handshake fire helpers and
// width helpers derived from the FIFO depth.
package frv_pipeline_source_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer width: indexes 0..depth-1 and wraps naturally for power-of-two depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Generic valid/ready transfer condition.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

  // Valid/busy transfer condition used toward the next pipeline stage.
  function automatic logic vb_fire(input logic valid, input logic busy);
    return valid & ~busy;
  endfunction

endpackage

// File: rtl/frv_pipeline_source_ram.sv
// DEPTH x RLEN storage array for the pipeline source FIFO.
// One synchronous write port, one asynchronous read port, contents not reset.
module frv_pipeline_source_ram
  import frv_pipeline_source_pkg::*;
#(
  parameter int unsigned RLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [ptr_width(DEPTH)-1:0]   waddr_i,
  input  logic [RLEN-1:0]               wdata_i,
  input  logic [ptr_width(DEPTH)-1:0]   raddr_i,
  output logic [RLEN-1:0]               rdata_o
);

  logic [RLEN-1:0] mem_q [DEPTH];

  // Write port: store one word per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read of the head entry.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/frv_pipeline_source.sv
// Transmitter end of the stage-to-stage valid/busy handshake: a small FIFO that
// accepts words on a ready/valid port and presents them in order as data/valid,
// honouring downstream busy back-pressure and flushing on redirects.
// Optional same-cycle empty bypass: define FRV_PIPELINE_SOURCE_BYPASS_EN.
module frv_pipeline_source
  import frv_pipeline_source_pkg::*;
#(
  parameter int unsigned RLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            g_clk,
  input  logic                            g_reset,
  input  logic                            w_valid,
  input  logic [RLEN-1:0]                 w_data,
  output logic                            w_ready,
  input  logic                            flush,
  output logic [RLEN-1:0]                 o_data,
  output logic                            o_valid,
  input  logic                            i_busy,
  output logic [level_width(DEPTH)-1:0]   o_level
);

  localparam int unsigned LW = level_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [RLEN-1:0] ram_rdata;

  logic empty;
  logic push;
  logic pop;
  logic store;

  assign empty = (level_q == '0);

  // Handshake decode; flush overrides both push and pop.
  always_comb begin
    w_ready = (level_q != LW'(DEPTH));
    push    = hs_fire(w_valid, w_ready) & ~flush;
    pop     = vb_fire(~empty, i_busy) & ~flush;
    store   = push;
`ifdef FRV_PIPELINE_SOURCE_BYPASS_EN
    // A word arriving into an empty FIFO that the next stage takes at once
    // never touches storage.
    if (empty && push && !i_busy) begin
      store = 1'b0;
    end
`endif
  end

  // Output presentation: head of storage, or the incoming word when bypassing.
  always_comb begin
    o_valid = ~empty;
    o_data  = ram_rdata;
    o_level = level_q;
`ifdef FRV_PIPELINE_SOURCE_BYPASS_EN
    if (empty && push) begin
      o_valid = 1'b1;
      o_data  = w_data;
    end
`endif
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end else begin
      if (store) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      unique case ({store, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
    end
  end

  frv_pipeline_source_ram #(
    .RLEN  (RLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (g_clk),
    .we_i    (store & ~g_reset),
    .waddr_i (wptr_q),
    .wdata_i (w_data),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_frv_pipeline_source.sv
// Directed self-checking bench for frv_pipeline_source (RLEN=32, DEPTH=4).
module tb_frv_pipeline_source;

  logic        g_clk;
  logic        g_reset;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic        flush;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_busy;
  logic [2:0]  o_level;

  int checks;
  int errors;

  frv_pipeline_source #(
    .RLEN  (32),
    .DEPTH (4)
  ) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .w_valid (w_valid),
    .w_data  (w_data),
    .w_ready (w_ready),
    .flush   (flush),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_busy  (i_busy),
    .o_level (o_level)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic write_busy(input logic [31:0] d);
    i_busy  = 1'b1;
    w_valid = 1'b1;
    w_data  = d;
    step();
    w_valid = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    g_reset = 1'b1;
    w_valid = 1'b1;
    w_data  = 32'h55;
    flush   = 1'b0;
    i_busy  = 1'b0;

    // Reset for two cycles with w_valid held high: nothing may be written.
    step();
    step();
    g_reset = 1'b0;
    w_valid = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(w_ready), 32'd1);
    check("rst_level", 32'(o_level), 32'd0);
    step();
    check("idle_level", 32'(o_level), 32'd0);

    // Fill with A0..A3 under busy, then drain in order.
    for (int i = 0; i < 4; i++) write_busy(32'hA0 + 32'(i));
    check("fill_level", 32'(o_level), 32'd4);
    check("fill_ready", 32'(w_ready), 32'd0);
    check("fill_head", o_data, 32'hA0);
    step();
    check("hold_head", o_data, 32'hA0);
    check("hold_valid", 32'(o_valid), 32'd1);
    i_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(o_valid), 32'd1);
      check("drain_data", o_data, 32'hA0 + 32'(i));
      step();
    end
    check("drain_empty", 32'(o_valid), 32'd0);
    check("drain_level", 32'(o_level), 32'd0);

    // Preload two, then ten cycles of concurrent push/pop across pointer wrap.
    write_busy(32'h10);
    write_busy(32'h11);
    i_busy  = 1'b0;
    w_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_data = 32'hB0 + 32'(i);
      #1;
      check("wrap_level", 32'(o_level), 32'd2);
      check("wrap_data", o_data, (i < 2) ? (32'h10 + 32'(i)) : (32'hB0 + 32'(i - 2)));
      step();
    end
    w_valid = 1'b0;
    check("wrap_tail0", o_data, 32'hB8);
    step();
    check("wrap_tail1", o_data, 32'hB9);
    step();
    check("wrap_empty", 32'(o_valid), 32'd0);

    // Full boundary: a write offered alongside a pop at level 4 is refused.
    for (int i = 0; i < 4; i++) write_busy(32'hC0 + 32'(i));
    i_busy  = 1'b0;
    w_valid = 1'b1;
    w_data  = 32'hCC;
    #1;
    check("full_ready", 32'(w_ready), 32'd0);
    step();
    check("full_freed", 32'(w_ready), 32'd1);
    check("full_level3", 32'(o_level), 32'd3);
    check("full_head", o_data, 32'hC1);
    i_busy = 1'b1;
    step();
    w_valid = 1'b0;
    check("full_level4", 32'(o_level), 32'd4);
    i_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("full_drain", o_data, (i < 3) ? (32'hC1 + 32'(i)) : 32'hCC);
      step();
    end
    check("full_empty", 32'(o_level), 32'd0);

    // Flush with a concurrent push and pop at level 3.
    for (int i = 0; i < 3; i++) write_busy(32'hD0 + 32'(i));
    i_busy  = 1'b0;
    w_valid = 1'b1;
    w_data  = 32'hDD;
    flush   = 1'b1;
    step();
    flush   = 1'b0;
    w_valid = 1'b0;
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_level", 32'(o_level), 32'd0);
    check("flush_ready", 32'(w_ready), 32'd1);
    write_busy(32'hE0);
    check("post_flush_data", o_data, 32'hE0);
    check("post_flush_level", 32'(o_level), 32'd1);
    i_busy = 1'b0;
    step();
    check("post_flush_empty", 32'(o_level), 32'd0);

    // Empty-FIFO latency: bypass build presents the word in the same cycle.
    i_busy  = 1'b0;
    w_valid = 1'b1;
    w_data  = 32'hF1;
    #1;
`ifdef FRV_PIPELINE_SOURCE_BYPASS_EN
    check("byp_valid", 32'(o_valid), 32'd1);
    check("byp_data", o_data, 32'hF1);
    check("byp_level", 32'(o_level), 32'd0);
    step();
    w_valid = 1'b0;
    #1;
    check("byp_after", 32'(o_valid), 32'd0);
    check("byp_after_level", 32'(o_level), 32'd0);
`else
    check("lat_same", 32'(o_valid), 32'd0);
    step();
    w_valid = 1'b0;
    check("lat_next_valid", 32'(o_valid), 32'd1);
    check("lat_next_data", o_data, 32'hF1);
    step();
    check("lat_drained", 32'(o_valid), 32'd0);
`endif

    // Reset mid-operation discards held entries.
    write_busy(32'h77);
    write_busy(32'h78);
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    check("midrst_level", 32'(o_level), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frv_pipeline_source.md
Name: frv_pipeline_source

Overview:
- Transmitter end of the core's stage-to-stage valid/busy handshake.
- Small FIFO that absorbs bursty producer traffic, e.g. fetch or memory responses, on a ready/valid write port.
- Presents entries in order to a downstream pipeline stage register as data/valid, obeying that stage's busy back-pressure.
- Supports flush for branch/trap redirects.

Parameters:
- RLEN, 32, width of each data word.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.

Ports:
- g_clk  input  1  global clock; all state updates on rising edge.
- g_reset  input  1  synchronous reset, active-high.
- w_valid  input  1  producer offers w_data this cycle.
- w_data  input  RLEN  producer data word.
- w_ready  output  1  FIFO can accept; write occurs when w_valid && w_ready.
- flush  input  1  discard all held and in-flight entries.
- o_data  output  RLEN  head entry presented to the next stage.
- o_valid  output  1  o_data holds a valid entry.
- i_busy  input  1  next stage cannot take data this cycle.
- o_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: single clock g_clk; reset g_reset is synchronous, active-high.
- Handshake terms:
  - Read (pop) occurs when o_valid && !i_busy.
  - Write (push) occurs when w_valid && w_ready && !flush.
- Reset: pointers=0, level=0. o_valid=0, w_ready=1, o_level=0. Storage contents are not reset.
- Reset mid-operation: identical to flush; all entries lost. Outputs take their reset values from the next edge.
- Flush:
  - Priority over push and pop in the same cycle.
  - Next cycle: level=0, o_valid=0, w_ready=1.
  - A write offered in the flush cycle is dropped.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
  - Full/empty are derived from the level counter, not from pointer compare.
- Signal definitions: o_valid = (level != 0); w_ready = (level != DEPTH); o_level = level.
- Latency: a write into an empty FIFO appears on o_valid/o_data at the next edge (1 cycle).
- Stability: while o_valid && i_busy, o_data and o_valid hold unchanged until the pop cycle or a flush.
- Order: strictly FIFO; no entry duplicated or dropped except on flush/reset.
- Simultaneous push and pop:
  - Level unchanged; both pointers advance.
  - Legal at any level 1..DEPTH-1.
  - At level=DEPTH, w_ready=0, so only the pop takes effect. The freed slot is visible through w_ready on the next cycle (no same-cycle full pass-through).
- Empty: i_busy is ignored; o_data is don't-care when o_valid=0.
- Producer side: holding w_valid while w_ready=0 is legal; nothing is written.

Optional Feature:
- Macro: FRV_PIPELINE_SOURCE_BYPASS_EN.
- Defined: when level=0 and a push occurs, o_valid=1 and o_data=w_data combinationally in the same cycle.
  - If additionally !i_busy, the word passes straight through and level stays 0.
  - Otherwise it is stored and presented from storage on the next cycle, with no value change.
  - Flush still suppresses the bypass (o_valid=0 in a flush cycle).
- Not defined: 1-cycle minimum latency as described under Behaviour; no combinational path from w_* to o_*.

Decomposition:
- Shared header (frv_common): handshake fire-condition helper macros, and the level-width expression $clog2(DEPTH)+1 as a constant function/define.
- One sub-module is natural: frv_pipeline_source_ram.
  - DEPTH x RLEN register array, one write port, one asynchronous read port, no reset.
  - Pointer/level control stays in the top module.

Test Plan:
- Reset then idle: assert g_reset 2 cycles -> o_valid=0, w_ready=1, o_level=0. Holding w_valid=1 during reset writes nothing.
- Fill/drain ordering (DEPTH=4): write 0xA0..0xA3 with i_busy=1 -> o_level=4, w_ready=0, o_data=0xA0 stable. Release i_busy -> reads 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then o_valid=0.
- Wrap + concurrent: preload 2 entries. Run 10 cycles of simultaneous push/pop with 0xB0..0xB9 -> o_level stays 2, output sequence continuous and in order across pointer wrap.
- Full boundary: at level 4 assert w_valid=1 (0xCC) with one pop -> 0xCC not written that cycle; w_ready=1 the next cycle; 0xCC accepted then and read last.
- Flush mid-stream: level 3 with push 0xDD and pop in the same cycle as flush -> next cycle o_valid=0, o_level=0. Later writes of 0xE0 read back as 0xE0, never 0xDD.
- Bypass (macro defined): empty, w_valid=1, w_data=0xF1, i_busy=0 -> o_valid=1, o_data=0xF1 the same cycle; o_level stays 0. Macro undefined -> o_valid rises one cycle later.
